// File: rtl/cla_sched_pkg.sv
// Shared types for the cla_add_sched adder scheduler: width default, FSM states, response record.
package cla_sched_pkg;

  localparam int CLA_WIDTH = 10;
  // Response id field is sized for the largest supported requester count (8)
  localparam int ID_MAXW   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FULL = 2'd1,
    LOCK = 2'd2
  } state_t;

  typedef struct packed {
    logic [ID_MAXW-1:0]   id;
    logic [CLA_WIDTH-1:0] sum;
    logic                 cout;
  } rsp_t;

endpackage

// File: rtl/cla_add_sched_if.sv
// Requester, adder and response signals of cla_add_sched. With CLA_SCHED_CARRY_CHAIN_EN
// the bundle also carries the per-requester req_last chain marker.
interface cla_add_sched_if
  import cla_sched_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_cin;
`ifdef CLA_SCHED_CARRY_CHAIN_EN
  logic [NREQ-1:0]       req_last;
`endif
  logic [WIDTH-1:0]      add_a;
  logic [WIDTH-1:0]      add_b;
  logic                  add_cin;
  logic [WIDTH-1:0]      add_s;
  logic                  add_cout;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;

  // Environment side: requesters, the shared adder and the response consumer
  modport master (
    output req_valid, req_a, req_b, req_cin,
`ifdef CLA_SCHED_CARRY_CHAIN_EN
    output req_last,
`endif
    output add_s, add_cout, rsp_ready,
    input  req_ready, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin,
`ifdef CLA_SCHED_CARRY_CHAIN_EN
    input  req_last,
`endif
    input  add_s, add_cout, rsp_ready,
    output req_ready, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first request above ptr (wrapping), or only lock_idx while lock_en.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            enable,
  input  logic            lock_en,
  input  logic [IDW-1:0]  lock_idx,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);

  logic [IDW-1:0]  cand [NREQ];
  logic [NREQ-1:0] hit;

  // Search slot gi examines requester (ptr + 1 + gi) mod NREQ
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
    logic [IDW:0] raw;
    assign raw       = {1'b0, ptr} + (IDW+1)'(gi + 1);
    assign cand[gi]  = (raw >= (IDW+1)'(NREQ)) ? IDW'(raw - (IDW+1)'(NREQ)) : raw[IDW-1:0];
    assign hit[gi]   = req[cand[gi]];
  end

  always_comb begin
    gnt = '0;
    idx = '0;
    if (enable) begin
      if (lock_en) begin
        if (req[lock_idx]) begin
          gnt[lock_idx] = 1'b1;
          idx           = lock_idx;
        end
      end else if (|hit) begin
        for (int k = NREQ - 1; k >= 0; k--) begin
          if (hit[k]) idx = cand[k];
        end
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cla_add_sched.sv
// Round-robin scheduler sharing one external adder among NREQ requesters, one registered response slot.
// Optional CLA_SCHED_CARRY_CHAIN_EN: multi-beat carry chains that lock the arbiter to one requester.
module cla_add_sched
  import cla_sched_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic           clk,
  input  logic           rst_n,
  cla_add_sched_if.slave bus
);

  state_t          state_q;
  rsp_t            rsp_q;
  logic [IDW-1:0]  rr_ptr_q;
  logic            rsp_valid_w;
  logic            slot_free;
  logic            accept;
  logic            lock_en;
  logic            cin_sel;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi] = bus.req_a[gi*WIDTH +: WIDTH];
    assign b_arr[gi] = bus.req_b[gi*WIDTH +: WIDTH];
  end

`ifdef CLA_SCHED_CARRY_CHAIN_EN
  logic rsp_valid_q;
  logic carry_q;
  // LOCK tracks the chain only; slot occupancy lives in rsp_valid_q
  assign rsp_valid_w = rsp_valid_q;
  assign lock_en     = (state_q == LOCK);
  assign cin_sel     = lock_en ? carry_q : bus.req_cin[gnt_idx];
`else
  assign rsp_valid_w = (state_q == FULL);
  assign lock_en     = 1'b0;
  assign cin_sel     = bus.req_cin[gnt_idx];
`endif

  // Gated by rst_n so no requester sees ready while reset is held
  assign slot_free = rst_n && (!rsp_valid_w || bus.rsp_ready);
  assign accept    = |gnt;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req      (bus.req_valid),
    .ptr      (rr_ptr_q),
    .enable   (slot_free),
    .lock_en  (lock_en),
    .lock_idx (rr_ptr_q),
    .gnt      (gnt),
    .idx      (gnt_idx)
  );

  assign bus.req_ready = gnt;
  assign bus.add_a     = accept ? a_arr[gnt_idx] : '0;
  assign bus.add_b     = accept ? b_arr[gnt_idx] : '0;
  assign bus.add_cin   = accept ? cin_sel : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rsp_q    <= '0;
      rr_ptr_q <= IDW'(NREQ - 1);
`ifdef CLA_SCHED_CARRY_CHAIN_EN
      rsp_valid_q <= 1'b0;
      carry_q     <= 1'b0;
`endif
    end else if (accept) begin
      rsp_q.id   <= ID_MAXW'(gnt_idx);
      rsp_q.sum  <= bus.add_s;
      rsp_q.cout <= bus.add_cout;
      rr_ptr_q   <= gnt_idx;
`ifdef CLA_SCHED_CARRY_CHAIN_EN
      rsp_valid_q <= 1'b1;
      if (!bus.req_last[gnt_idx]) begin
        state_q <= LOCK;
        carry_q <= bus.add_cout;
      end else begin
        state_q <= FULL;
      end
`else
      state_q <= FULL;
`endif
    end else if (bus.rsp_ready) begin
`ifdef CLA_SCHED_CARRY_CHAIN_EN
      rsp_valid_q <= 1'b0;
`endif
      if (state_q == FULL) state_q <= IDLE;
    end
  end

  assign bus.rsp_valid = rsp_valid_w;
  assign bus.rsp_id    = rsp_q.id[IDW-1:0];
  assign bus.rsp_sum   = rsp_q.sum;
  assign bus.rsp_cout  = rsp_q.cout;

  // Upper id bits are only meaningful for larger requester counts
  logic unused_id_bits;
  assign unused_id_bits = ^rsp_q.id;

endmodule

// File: tb/tb_cla_add_sched.sv
// Bench for cla_add_sched: directed steps plus random traffic against a queue-free arithmetic model.
// Covers CLA_SCHED_CARRY_CHAIN_EN when the macro is defined for the whole compile.
module tb_cla_add_sched;
  localparam int W  = 10;
  localparam int N  = 4;
  localparam int IW = $clog2(N);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cla_add_sched_if #(.WIDTH(W), .NREQ(N)) bus ();
  cla_add_sched #(.WIDTH(W), .NREQ(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Stand-in for the external shared adder
  assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {{W{1'b0}}, bus.add_cin};

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] op_a [N];
  logic [W-1:0] op_b [N];
  bit           op_v [N];
  bit           op_cin [N];
  bit           op_last [N];

  bit m_valid, m_cout, m_lock, m_carry;
  int m_id, m_sum, m_ptr;
  int grants[$];
  int exp_order[6] = '{0, 1, 2, 3, 0, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]      = op_v[i];
      bus.req_a[i*W +: W]   = op_a[i];
      bus.req_b[i*W +: W]   = op_b[i];
      bus.req_cin[i]        = op_cin[i];
`ifdef CLA_SCHED_CARRY_CHAIN_EN
      bus.req_last[i]       = op_last[i];
`endif
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_cout = 0; m_lock = 0; m_carry = 0;
    m_id = 0; m_sum = 0; m_ptr = N - 1;
  endtask

  task automatic set_op(input int i, input int a, input int b, input bit cin, input bit last);
    op_v[i] = 1; op_a[i] = W'(a); op_b[i] = W'(b); op_cin[i] = cin; op_last[i] = last;
  endtask

  task automatic clear_ops();
    for (int i = 0; i < N; i++) begin
      op_v[i] = 0; op_a[i] = '0; op_b[i] = '0; op_cin[i] = 0; op_last[i] = 1;
    end
  endtask

  task automatic refill_all();
    for (int i = 0; i < N; i++)
      if (!op_v[i]) set_op(i, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'($urandom), 1'b1);
  endtask

  function automatic int pick();
    if (m_valid && !bus.rsp_ready) return -1;
    if (m_lock) return op_v[m_ptr] ? m_ptr : -1;
    for (int k = 1; k <= N; k++)
      if (op_v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  // One cycle: entered just after a falling edge, leaves at the next falling edge
  task automatic step();
    int g, s;
    logic [W-1:0] ea, eb;
    logic ec;
    logic [N-1:0] er;
    apply();
    #1;
    g = pick();
    er = '0; ea = '0; eb = '0; ec = 1'b0;
    if (g >= 0) begin
      er[g] = 1'b1; ea = op_a[g]; eb = op_b[g];
      ec = m_lock ? m_carry : op_cin[g];
    end
    chk("req_ready", 32'(bus.req_ready), 32'(er));
    chk("add_a", 32'(bus.add_a), 32'(ea));
    chk("add_b", 32'(bus.add_b), 32'(eb));
    chk("add_cin", 32'(bus.add_cin), 32'(ec));
    @(posedge clk);
    #1;
    if (g >= 0) begin
      s = int'(ea) + int'(eb) + int'(ec);
      m_sum = s % (1 << W); m_cout = (s >= (1 << W));
      m_id = g; m_valid = 1; m_ptr = g;
`ifdef CLA_SCHED_CARRY_CHAIN_EN
      m_lock = !op_last[g];
      if (m_lock) m_carry = m_cout;
`endif
      op_v[g] = 0;
      grants.push_back(g);
    end else if (bus.rsp_ready) begin
      m_valid = 0;
    end
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
    chk("rsp_id", 32'(bus.rsp_id), 32'(m_id));
    chk("rsp_sum", 32'(bus.rsp_sum), 32'(m_sum));
    chk("rsp_cout", 32'(bus.rsp_cout), 32'(m_cout));
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_id"}, 32'(bus.rsp_id), 32'd0);
    chk({tag, "_sum"}, 32'(bus.rsp_sum), 32'd0);
    chk({tag, "_cout"}, 32'(bus.rsp_cout), 32'd0);
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    apply();
    model_reset();
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      check_reset_state("reset");
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_ops();
    refill_all();
    bus.rsp_ready = 1'b1;
    apply();
    @(negedge clk);
    do_reset();

    // Single request: 0x3FF + 0x001 wraps to 0 with carry out
    clear_ops();
    set_op(0, 'h3FF, 'h001, 1'b0, 1'b1);
    step();
    chk("single_valid", 32'(bus.rsp_valid), 32'd1);
    chk("single_id", 32'(bus.rsp_id), 32'd0);
    chk("single_sum", 32'(bus.rsp_sum), 32'h000);
    chk("single_cout", 32'(bus.rsp_cout), 32'd1);

    // Fairness from reset with every requester always valid
    refill_all();
    do_reset();
    grants.delete();
    for (int i = 0; i < 6; i++) begin
      step();
      chk("fair_id", 32'(bus.rsp_id), 32'(exp_order[i]));
      chk("fair_valid", 32'(bus.rsp_valid), 32'd1);
      refill_all();
    end

    // Backpressure with only requester 2 pending
    for (int i = 0; i < N; i++) if (i != 2) op_v[i] = 0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_id", 32'(bus.rsp_id), 32'd1);
    end
    bus.rsp_ready = 1'b1;
    step();
    chk("bp_release_id", 32'(bus.rsp_id), 32'd2);
    chk("bp_release_valid", 32'(bus.rsp_valid), 32'd1);

    // Asynchronous reset while a response is held
    refill_all();
    apply();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    chk("async_rst_hold_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_first_id", 32'(bus.rsp_id), 32'd0);

    // Two-beat carry chain from requester 1, requester 0 competing on the second beat
    clear_ops();
    do_reset();
    set_op(1, 'h3FF, 'h001, 1'b0, 1'b0);
    step();
    chk("chain_b1_id", 32'(bus.rsp_id), 32'd1);
    set_op(0, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'($urandom), 1'b1);
    set_op(1, 'h000, 'h000, 1'b0, 1'b1);
    step();
`ifdef CLA_SCHED_CARRY_CHAIN_EN
    chk("chain_b2_id", 32'(bus.rsp_id), 32'd1);
    chk("chain_b2_sum", 32'(bus.rsp_sum), 32'h001);
    chk("chain_b2_cout", 32'(bus.rsp_cout), 32'd0);
    step();
    chk("chain_after_id", 32'(bus.rsp_id), 32'd0);
`else
    chk("nochain_mid_id", 32'(bus.rsp_id), 32'd0);
    step();
    chk("nochain_b2_id", 32'(bus.rsp_id), 32'd1);
    chk("nochain_b2_sum", 32'(bus.rsp_sum), 32'h000);
    chk("nochain_b2_cout", 32'(bus.rsp_cout), 32'd0);
`endif

    // Random traffic: arrivals, drops, and consumer stalls
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!op_v[i]) begin
          if ($urandom_range(0, 1) == 1)
            set_op(i, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                   1'($urandom), 1'($urandom_range(0, 1)));
        end else if ($urandom_range(0, 15) == 0) begin
          op_v[i] = 0;
        end
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cla_add_sched.md
Name: cla_add_sched

Overview:
- Round-robin scheduler that shares one combinational 10-bit cla_adder instance among NREQ requesters.
- Each requester presents operands over a valid/ready handshake; the scheduler grants one per cycle, drives the adder operand ports, and registers sum/cout with the requester ID into a single response slot with backpressure.
- Sits between the operand producers and the shared adder datapath.

Parameters:
- WIDTH, 10, operand/sum width; must match the adder instance.
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), requester ID width.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester operand valid.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- req_a  input  NREQ*WIDTH  operand A, slice i belongs to requester i.
- req_b  input  NREQ*WIDTH  operand B, slice i.
- req_cin  input  NREQ  carry-in per requester.
- add_a  output  WIDTH  to the adder's a.
- add_b  output  WIDTH  to the adder's b.
- add_cin  output  1  to the adder's cin.
- add_s  input  WIDTH  from the adder's s.
- add_cout  input  1  from the adder's cout.
- rsp_valid  output  1  response slot occupied.
- rsp_ready  input  1  consumer accepts response.
- rsp_id  output  IDW  requester index of the response.
- rsp_sum  output  WIDTH  registered sum.
- rsp_cout  output  1  registered carry-out.

Behaviour:
- Reset (async assert, sync-release usage assumed upstream): rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, rr_ptr=NREQ-1, state=IDLE; req_ready=0 while rst_n=0.
- Slot free: free = !rsp_valid || rsp_ready.
- Grant:
  - When free, the arbiter picks the first asserted req_valid searching from rr_ptr+1 upward, wrapping modulo NREQ.
  - req_ready[g]=1 combinationally, for that requester only.
  - No grant when not free; req_ready=0.
- Accept cycle (req_valid[g] && req_ready[g]):
  - add_a/add_b/add_cin = req_a[g]/req_b[g]/req_cin[g].
  - At the clock edge: rsp_sum<=add_s, rsp_cout<=add_cout, rsp_id<=g, rsp_valid<=1, rr_ptr<=g.
- Idle operand ports: when no grant, add_a/add_b/add_cin are driven 0 (no toggling).
- Latency: response visible one cycle after accept. Throughput is one op/cycle when rsp_ready is held 1.
- Drain: rsp_valid && rsp_ready with no new accept -> rsp_valid<=0; rsp_sum/rsp_cout/rsp_id hold their last values.
- Simultaneous drain and accept: the slot is overwritten with the new result and rsp_valid stays 1. No bubble.
- Backpressure: while rsp_valid && !rsp_ready, the response fields are stable and no requester is granted.
- Protocol: a requester holds req_valid and its payload stable until accepted. Deasserting req_valid before acceptance is legal; that request is lost, not an error.
- States:
  - IDLE: rsp_valid=0.
  - FULL: rsp_valid=1.
  - LOCK: only with CARRY_CHAIN_EN. Transitions are per the rules above.
- Reset mid-operation: the pending response is discarded and no req_ready pulses during reset.
- Arithmetic: modulo 2^WIDTH, carry reported only in rsp_cout; no internal widening.

Optional Feature:
- Macro: CLA_SCHED_CARRY_CHAIN_EN.
- Defined:
  - Adds input port req_last (NREQ bits).
  - Accepting a beat with req_last[g]=0 enters LOCK: the arbiter grants only g, and add_cin is taken from an internal carry register loaded with add_cout (req_cin ignored).
  - Accepting with req_last[g]=1 returns to normal arbitration with rr_ptr=g.
  - The first beat of a chain uses req_cin.
  - If g drops req_valid while locked, the lock persists; other requesters wait.
  - Reset clears the lock and the carry register.
- Undefined: req_last is absent, every beat uses its own req_cin, and LOCK does not exist.

Decomposition:
- Package cla_sched_pkg holds:
  - WIDTH default constant.
  - State enum {IDLE, FULL, LOCK}.
  - Response struct typedef {id, sum, cout}.
- Sub-module rr_arbiter (NREQ; inputs req, ptr, enable, optional lock_en/lock_idx; outputs one-hot gnt and encoded idx).
- The adder itself stays outside, instantiated beside this block.

Test Plan:
- Single request: req0 a=10'h3FF, b=10'h001, cin=0, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_sum=10'h000, rsp_cout=1.
- Fairness: all four requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1 from reset; one result per cycle.
- Backpressure: rsp_ready=0 for 3 cycles with req2 valid -> req_ready=0 throughout, response fields stable. rsp_ready=1 -> same cycle req_ready[2]=1, next result without a bubble.
- Async reset mid-stream: assert rst_n=0 while rsp_valid=1 -> rsp_valid, rsp_sum, rsp_cout go 0 immediately. After release, the first grant goes to requester 0.
- Carry chain (macro on): req1 beats {a=10'h3FF, b=10'h001, cin=0, last=0} then {a=0, b=0, last=1} while req0 is also valid -> req0 is not granted between the beats. Second response: sum=10'h001, cout=0.
- Carry chain off: same stimulus minus last, with cin=0 on the second beat -> second beat from req1 has sum=10'h000; req0 is granted between the beats.
